// File: rtl/branch_sequencer.sv
// PC / flag-register owner and branch resolver for the fetch path; FETCH_REQ is combinational, branches resolve in one RESOLVE cycle.
// STALL only gates FETCH_REQ; BRANCH_BUSY tells the issuer when a new branch will not be accepted.
module branch_sequencer #(
   parameter int              PC_W         = 16,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   output logic            FETCH_REQ,
   input  logic            FETCH_ACK,
   output logic [PC_W-1:0] PC,
   input  logic            STALL,
   input  logic            FLAG_WE,
   input  logic            ZERO_IN,
   input  logic            EQUAL_IN,
   input  logic            GT_IN,
   input  logic            LT_IN,
   output logic            ZERO_FLAG,
   output logic            EQUAL_FLAG,
   output logic            GT_FLAG,
   output logic            LT_FLAG,
   input  logic            BRANCH_REQ,
   input  logic [3:0]      BRANCH_COND,
   input  logic [PC_W-1:0] BRANCH_TARGET,
   output logic            BRANCH_BUSY,
   output logic            BRANCH_TAKEN,
   output logic            FLUSH,
   input  logic            HALT,
   output logic            HALTED
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RESOLVE = 2'd2,
      HALT_ST = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] tgt_q;
   logic [3:0]      cond_q;
   logic [3:0]      flag_q;   // {Z, EQ, GT, LT}
   logic            taken_q;
   logic            capture;
   logic            sel_flag;
   logic            cond_true;
   logic            resolve_taken;

   // Resolution uses the registered flags, so a FLAG_WE in RESOLVE lands too late to matter.
   always_comb begin
      sel_flag = 1'b0;
      case (cond_q[1:0])
         2'd0:    sel_flag = flag_q[3];
         2'd1:    sel_flag = flag_q[2];
         2'd2:    sel_flag = flag_q[1];
         default: sel_flag = flag_q[0];
      endcase
      cond_true = !cond_q[3] || (sel_flag ^ cond_q[2]);
   end

   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      FETCH_REQ     = 1'b0;
      BRANCH_BUSY   = 1'b1;
      HALTED        = 1'b0;
      resolve_taken = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = RUN;
         end
         RUN: begin
            FETCH_REQ   = !STALL;
            BRANCH_BUSY = 1'b0;
            if (HALT) begin
               state_d = HALT_ST;
            end else if (BRANCH_REQ) begin
               state_d = RESOLVE;
               capture = 1'b1;
            end
         end
         RESOLVE: begin
            resolve_taken = cond_true;
            state_d       = RUN;
         end
         default: begin
            HALTED = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         tgt_q   <= '0;
         cond_q  <= '0;
         flag_q  <= '0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         taken_q <= resolve_taken;
         if (resolve_taken) begin
            pc_q <= tgt_q;
         end else if (FETCH_REQ && FETCH_ACK) begin
            pc_q <= pc_q + PC_W'(1);
         end
         if (capture) begin
            cond_q <= BRANCH_COND;
            tgt_q  <= BRANCH_TARGET;
         end
         if (FLAG_WE && (state_q != IDLE)) begin
            flag_q <= {ZERO_IN, EQUAL_IN, GT_IN, LT_IN};
         end
      end
   end

   assign PC           = pc_q;
   assign FLUSH        = taken_q;
   assign BRANCH_TAKEN = taken_q;
   assign ZERO_FLAG    = flag_q[3];
   assign EQUAL_FLAG   = flag_q[2];
   assign GT_FLAG      = flag_q[1];
   assign LT_FLAG      = flag_q[0];

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed vector table for the fetch/branch corner cases, then random traffic against a behavioural model.
module tb_branch_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FETCH_ACK = 1'b0, STALL = 1'b0, FLAG_WE = 1'b0;
   logic        ZERO_IN = 1'b0, EQUAL_IN = 1'b0, GT_IN = 1'b0, LT_IN = 1'b0;
   logic        BRANCH_REQ = 1'b0, HALT = 1'b0;
   logic [3:0]  BRANCH_COND = '0;
   logic [15:0] BRANCH_TARGET = '0;
   logic        FETCH_REQ, ZERO_FLAG, EQUAL_FLAG, GT_FLAG, LT_FLAG;
   logic        BRANCH_BUSY, BRANCH_TAKEN, FLUSH, HALTED;
   logic [15:0] PC;

   branch_sequencer #(.PC_W(16), .RESET_VECTOR(16'h0000)) dut (
      .CLK(CLK), .RESET(RESET), .FETCH_REQ(FETCH_REQ), .FETCH_ACK(FETCH_ACK), .PC(PC),
      .STALL(STALL), .FLAG_WE(FLAG_WE), .ZERO_IN(ZERO_IN), .EQUAL_IN(EQUAL_IN),
      .GT_IN(GT_IN), .LT_IN(LT_IN), .ZERO_FLAG(ZERO_FLAG), .EQUAL_FLAG(EQUAL_FLAG),
      .GT_FLAG(GT_FLAG), .LT_FLAG(LT_FLAG), .BRANCH_REQ(BRANCH_REQ),
      .BRANCH_COND(BRANCH_COND), .BRANCH_TARGET(BRANCH_TARGET), .BRANCH_BUSY(BRANCH_BUSY),
      .BRANCH_TAKEN(BRANCH_TAKEN), .FLUSH(FLUSH), .HALT(HALT), .HALTED(HALTED)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, stall, ack, we;
      logic [3:0]  fin;
      logic        breq;
      logic [3:0]  cond;
      logic [15:0] tgt;
      logic        halt;
      logic [24:0] exp;   // {pc, fetch_req, flush, taken, busy, halted, Z, EQ, GT, LT}
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   failures = 0;

   // Behavioural model: a core that has started, may be halted, and may hold one unresolved branch.
   bit          m_started, m_halted, m_pending, m_pulse;
   logic [3:0]  m_cond, m_flags;
   logic [15:0] m_tgt, m_pc;

   function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
      if (!c[3]) return 1'b1;
      return f[3 - c[1:0]] ^ c[2];
   endfunction

   task automatic model_reset();
      m_started = 0; m_halted = 0; m_pending = 0; m_pulse = 0;
      m_cond = '0; m_tgt = '0; m_pc = 16'h0000; m_flags = '0;
   endtask

   function automatic logic [24:0] model_out();
      bit running;
      running = m_started && !m_halted && !m_pending;
      return {m_pc, running && !STALL, m_pulse, m_pulse, !running, m_halted, m_flags};
   endfunction

   task automatic model_edge();
      logic [3:0] nf;
      bit taken;
      if (RESET) begin
         model_reset();
         return;
      end
      nf = (FLAG_WE && m_started) ? {ZERO_IN, EQUAL_IN, GT_IN, LT_IN} : m_flags;
      taken = 0;
      if (!m_started) begin
         m_started = 1;
      end else if (m_pending) begin
         taken = cond_true(m_cond, m_flags);
         if (taken) m_pc = m_tgt;
         m_pending = 0;
      end else if (!m_halted) begin
         if (!STALL && FETCH_ACK) m_pc = m_pc + 16'd1;
         if (HALT) m_halted = 1;
         else if (BRANCH_REQ) begin
            m_pending = 1; m_cond = BRANCH_COND; m_tgt = BRANCH_TARGET;
         end
      end
      m_flags = nf;
      m_pulse = taken;
   endtask

   task automatic add(input logic rst, stall, ack, we, input logic [3:0] fin, input logic breq,
                      input logic [3:0] cond, input logic [15:0] tgt, input logic halt,
                      input logic [15:0] pc, input logic fr, pl, busy, hlt, input logic [3:0] fl);
      vec_t v;
      v.rst = rst; v.stall = stall; v.ack = ack; v.we = we; v.fin = fin; v.breq = breq;
      v.cond = cond; v.tgt = tgt; v.halt = halt;
      v.exp = {pc, fr, pl, pl, busy, hlt, fl};
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      RESET = v.rst; STALL = v.stall; FETCH_ACK = v.ack; FLAG_WE = v.we;
      {ZERO_IN, EQUAL_IN, GT_IN, LT_IN} = v.fin;
      BRANCH_REQ = v.breq; BRANCH_COND = v.cond; BRANCH_TARGET = v.tgt; HALT = v.halt;
      if (v.rst) model_reset();
   endtask

   task automatic run_cycle(input string name, input bit use_exp, input logic [24:0] exp);
      logic [24:0] act, want;
      @(negedge CLK);
      act  = {PC, FETCH_REQ, FLUSH, BRANCH_TAKEN, BRANCH_BUSY, HALTED,
              ZERO_FLAG, EQUAL_FLAG, GT_FLAG, LT_FLAG};
      want = use_exp ? exp : model_out();
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got pc=%h req,fl,tk,busy,hlt,ZEGL=%b expected pc=%h %b",
                  name, act[24:9], act[8:0], want[24:9], want[8:0]);
      end
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   initial begin
      //  rst st ak we fin     rq cond    tgt       hl   pc        fr pl bz hl flags
      add(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 0, 0, 1, 0, 4'b0000);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 0, 0, 1, 0, 4'b0000);
      for (int i = 0; i < 5; i++)
         add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'(i), 1, 0, 0, 0, 4'b0000);
      for (int i = 0; i < 3; i++)
         add(0, 1, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0005, 0, 0, 0, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0005, 1, 0, 0, 0, 4'b0000);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0005, 1, 0, 0, 0, 4'b0000);
      // taken EQ branch using the same-cycle flag write
      add(0, 0, 0, 1, 4'b0100, 1, 4'b1001, 16'h0040, 0,  16'h0006, 1, 0, 0, 0, 4'b0000);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0006, 0, 0, 1, 0, 4'b0100);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0040, 1, 1, 0, 0, 4'b0100);
      // unconditional to 0x22 with an acked fetch in the request cycle, then to 0x10
      add(0, 0, 1, 1, 4'b1000, 1, 4'b0000, 16'h0022, 0,  16'h0041, 1, 0, 0, 0, 4'b0100);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0042, 0, 0, 1, 0, 4'b1000);
      add(0, 0, 0, 0, 4'b0000, 1, 4'b0000, 16'h0010, 0,  16'h0022, 1, 1, 0, 0, 4'b1000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0022, 0, 0, 1, 0, 4'b1000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0010, 1, 1, 0, 0, 4'b1000);
      // NOT Z with Z=1: not taken
      add(0, 0, 1, 0, 4'b0000, 1, 4'b1100, 16'h0080, 0,  16'h0010, 1, 0, 0, 0, 4'b1000);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0011, 0, 0, 1, 0, 4'b1000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0011, 1, 0, 0, 0, 4'b1000);
      // GT branch with the flag write arriving during RESOLVE
      add(0, 0, 0, 0, 4'b0000, 1, 4'b1010, 16'h0099, 0,  16'h0011, 1, 0, 0, 0, 4'b1000);
      add(0, 0, 0, 1, 4'b0010, 0, 4'b0000, 16'h0000, 0,  16'h0011, 0, 0, 1, 0, 4'b1000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0011, 1, 0, 0, 0, 4'b0010);
      // PC wrap through 0xFFFF
      add(0, 0, 0, 0, 4'b0000, 1, 4'b0000, 16'hFFFE, 0,  16'h0011, 1, 0, 0, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0011, 0, 0, 1, 0, 4'b0010);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'hFFFE, 1, 1, 0, 0, 4'b0010);
      add(0, 0, 1, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'hFFFF, 1, 0, 0, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 1, 0, 0, 0, 4'b0010);
      // HALT beats BRANCH_REQ; flags stay writable while halted
      add(0, 0, 1, 0, 4'b0000, 1, 4'b0000, 16'h0055, 1,  16'h0000, 1, 0, 0, 0, 4'b0010);
      add(0, 0, 1, 1, 4'b0001, 0, 4'b0000, 16'h0000, 0,  16'h0001, 0, 0, 1, 1, 4'b0010);
      add(0, 0, 1, 0, 4'b0000, 1, 4'b0000, 16'h0055, 0,  16'h0001, 0, 0, 1, 1, 4'b0001);
      // reset while a taken branch sits in RESOLVE
      add(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 0, 0, 1, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 0, 0, 1, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000, 1, 4'b0000, 16'h0077, 0,  16'h0000, 1, 0, 0, 0, 4'b0000);
      add(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 0, 0, 1, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 0, 0, 1, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 16'h0000, 0,  16'h0000, 1, 0, 0, 0, 4'b0000);

      model_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         run_cycle($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
      end

      for (int n = 0; n < 4000; n++) begin
         vec_t r;
         r.rst   = (n == 0) || ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 15) == 0);
         r.stall = ($urandom_range(0, 3) == 0);
         r.ack   = ($urandom_range(0, 9) < 6);
         r.we    = ($urandom_range(0, 2) == 0);
         r.fin   = 4'($urandom);
         r.breq  = ($urandom_range(0, 4) == 0);
         r.cond  = 4'($urandom);
         r.tgt   = 16'($urandom);
         r.halt  = ($urandom_range(0, 99) == 0);
         r.exp   = '0;
         apply(r);
         run_cycle($sformatf("rnd%0d", n), 1'b0, r.exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Program-counter and branch-resolution controller for the CPU fetch path.
- Owns the architectural flag register (Z, EQ, GT, LT) and the PC.
- Drives the instruction-fetch request/ack handshake.
- Resolves conditional branches using the 4-bit condition encoding, then redirects fetch and flushes the pipeline when a branch is taken.

Parameters:
- PC_W, 16, PC and branch-target width.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FETCH_REQ  out  1  fetch request for the instruction at PC.
- FETCH_ACK  in  1  memory accepted the fetch at PC this cycle.
- PC  out  PC_W  current fetch address.
- STALL  in  1  suppresses FETCH_REQ; does not freeze state.
- FLAG_WE  in  1  load the flag register from the *_IN inputs.
- ZERO_IN, EQUAL_IN, GT_IN, LT_IN  in  1 each  ALU result flags.
- ZERO_FLAG, EQUAL_FLAG, GT_FLAG, LT_FLAG  out  1 each  flag register contents.
- BRANCH_REQ  in  1  branch instruction presented; one-cycle pulse.
- BRANCH_COND  in  4  condition code.
- BRANCH_TARGET  in  PC_W  target address.
- BRANCH_BUSY  out  1  high while not in RUN; new branches are not accepted.
- BRANCH_TAKEN  out  1  one-cycle pulse, branch taken.
- FLUSH  out  1  one-cycle pulse; younger in-flight instructions are discarded.
- HALT  in  1  stop fetching.
- HALTED  out  1  core halted.

Behaviour:
- **Reset (async):**
  - state=IDLE, PC=RESET_VECTOR.
  - All four flags=0.
  - FLUSH, BRANCH_TAKEN and HALTED=0.
  - Captured condition/target registers=0.
  - FETCH_REQ=0 and BRANCH_BUSY=1 (state is not RUN).
- **States:** IDLE, RUN, RESOLVE, HALT_ST.
- **IDLE:** unconditionally moves to RUN on the first clock after RESET deasserts.
- **FETCH_REQ:** combinational, = (state==RUN) & !STALL.
- **PC increment:** PC <= PC+1 (mod 2^PC_W; 2^PC_W-1 wraps to 0) on any cycle with FETCH_REQ & FETCH_ACK. FETCH_ACK while FETCH_REQ=0 is ignored.
- **Flag register:**
  - FLAG_WE loads all four flags at the clock edge, in every state except IDLE.
  - FLAG_WE is otherwise independent of the state machine.
- **Condition evaluation (combinational on registered flags and captured code):**
  - bit3=0 → always true.
  - Else the flag selected by [1:0] (0=Z, 1=EQ, 2=GT, 3=LT), XOR bit2 (invert).
- **RUN:**
  - HALT=1 → HALT_ST. HALT has priority over BRANCH_REQ, and that branch is dropped.
  - Else BRANCH_REQ=1 → capture BRANCH_COND and BRANCH_TARGET, go to RESOLVE.
  - A fetch acked in the same cycle as BRANCH_REQ still increments PC.
- **RESOLVE (exactly one cycle):**
  - Evaluates the captured condition against the flag register.
  - The flag register includes any FLAG_WE from the BRANCH_REQ cycle, so same-cycle flag writes are seen.
  - FLAG_WE asserted during RESOLVE does not affect this resolution.
  - Taken: PC <= target, FLUSH=1 and BRANCH_TAKEN=1 for one cycle (registered, visible the cycle after RESOLVE), → RUN.
  - Not taken: PC unchanged, no pulses, → RUN.
  - BRANCH_REQ and HALT are ignored in RESOLVE; the issuer must observe BRANCH_BUSY.
- **Branch bubble:** exactly one cycle with no fetch. The first fetch at the target is issued the cycle FLUSH is high.
- **HALT_ST:** FETCH_REQ=0, HALTED=1, PC frozen, flags still writable. Exit only via RESET.
- **BRANCH_BUSY:** = (state != RUN).
- **Reset mid-RESOLVE:** the pending branch is discarded and no FLUSH is issued.

Test Plan:
- **Reset / sequential fetch:**
  - Stimulus: release RESET; hold FETCH_ACK=1, STALL=0.
  - Required: FETCH_REQ=0 for the first cycle (IDLE), then 1. PC = 0,1,2,3 on successive cycles.
  - With PC_W=4, PC wraps from 15 to 0.
- **Stall / ignored ack:**
  - Stimulus: STALL=1 for 3 cycles at PC=5, FETCH_ACK=1 throughout.
  - Required: FETCH_REQ=0 and PC stays 5. After STALL drops, PC advances to 6 on the next ack.
- **Taken branch with same-cycle flag write:**
  - Stimulus: flags all 0; BRANCH_REQ with COND=4'b1001 (test EQ), TARGET=0x40, in the same cycle as FLAG_WE with EQUAL_IN=1.
  - Required: BRANCH_BUSY=1 for one cycle; next cycle FLUSH=1, BRANCH_TAKEN=1, PC=0x40, FETCH_REQ=1.
- **Inverted not-taken branch:**
  - Stimulus: flags Z=1; BRANCH_REQ with COND=4'b1100 (NOT Z), TARGET=0x80, at PC=0x10 with FETCH_ACK=1.
  - Required: PC=0x11 after the request cycle, no FLUSH, no BRANCH_TAKEN, RUN resumes.
- **Unconditional branch / late flag write:**
  - Unconditional: COND=4'b0000, TARGET=0x22 → taken regardless of flags.
  - Late write: FLAG_WE during RESOLVE with COND=4'b1010 (GT), GT previously 0 → not taken; GT_FLAG=1 afterwards.
- **HALT priority and reset mid-branch:**
  - HALT and BRANCH_REQ in the same cycle → HALTED=1, FETCH_REQ=0, no FLUSH, PC frozen.
  - RESET asserted during RESOLVE → PC=RESET_VECTOR, no FLUSH pulse.
